// File: rtl/instr_encoder_pkg.sv
// Shared MIPS encoding constants, mnemonic indices and encoder FSM states.
// Also holds small helpers that pack the R/I/J instruction formats.
package instr_encoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef enum logic [4:0] {
        MnAdd   = 5'd0,  MnAddu  = 5'd1,  MnSub  = 5'd2,  MnSubu = 5'd3,
        MnAnd   = 5'd4,  MnOr    = 5'd5,  MnXor  = 5'd6,  MnNor  = 5'd7,
        MnSlt   = 5'd8,  MnSltu  = 5'd9,  MnSll  = 5'd10, MnSrl  = 5'd11,
        MnSra   = 5'd12, MnJr    = 5'd13, MnJalr = 5'd14, MnLw   = 5'd15,
        MnSw    = 5'd16, MnLui   = 5'd17, MnAddi = 5'd18, MnAddiu = 5'd19,
        MnAndi  = 5'd20, MnSlti  = 5'd21, MnSltiu = 5'd22, MnBeq = 5'd23,
        MnJ     = 5'd24, MnJal   = 5'd25
    } mnem_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2
    } state_e;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Symbolic-instruction stream, instruction-memory write port and status of the encoder.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MNEM_W = 5
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              in_valid;
    logic              in_ready;
    logic [MNEM_W-1:0] in_mnem;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [15:0]       instr_count;
    logic              err_illegal;
    logic              done;

    // Encoder side.
    modport slave (
        input  start, start_addr, in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt,
               in_imm, in_target, in_last, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, instr_count, err_illegal, done
    );

    // Loader / memory side.
    modport master (
        output start, start_addr, in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt,
               in_imm, in_target, in_last, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, instr_count, err_illegal, done
    );
endinterface

// File: rtl/instr_encode_comb.sv
// Combinational mnemonic + fields -> 32-bit MIPS word, with an illegal-mnemonic flag.
module instr_encode_comb
    import instr_encoder_pkg::*;
#(
    parameter int unsigned MNEM_W = 5
) (
    input  logic [MNEM_W-1:0] mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic [31:0]       word,
    output logic              illegal
);

    logic [31:0] mnem_ext;
    logic [4:0]  idx;

    assign mnem_ext = 32'(mnem);
    assign idx      = mnem_ext[4:0];

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        unique case (idx)
            MnAdd:   word = enc_r(rs, rt, rd, 5'd0, FN_ADD);
            MnAddu:  word = enc_r(rs, rt, rd, 5'd0, FN_ADDU);
            MnSub:   word = enc_r(rs, rt, rd, 5'd0, FN_SUB);
            MnSubu:  word = enc_r(rs, rt, rd, 5'd0, FN_SUBU);
            MnAnd:   word = enc_r(rs, rt, rd, 5'd0, FN_AND);
            MnOr:    word = enc_r(rs, rt, rd, 5'd0, FN_OR);
            MnXor:   word = enc_r(rs, rt, rd, 5'd0, FN_XOR);
            MnNor:   word = enc_r(rs, rt, rd, 5'd0, FN_NOR);
            MnSlt:   word = enc_r(rs, rt, rd, 5'd0, FN_SLT);
            MnSltu:  word = enc_r(rs, rt, rd, 5'd0, FN_SLTU);
            MnSll:   word = enc_r(5'd0, rt, rd, shamt, FN_SLL);
            MnSrl:   word = enc_r(5'd0, rt, rd, shamt, FN_SRL);
            MnSra:   word = enc_r(5'd0, rt, rd, shamt, FN_SRA);
            MnJr:    word = enc_r(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            MnJalr:  word = enc_r(rs, 5'd0, rd, 5'd0, FN_JALR);
            MnLw:    word = enc_i(OP_LW, rs, rt, imm);
            MnSw:    word = enc_i(OP_SW, rs, rt, imm);
            MnLui:   word = enc_i(OP_LUI, 5'd0, rt, imm);
            MnAddi:  word = enc_i(OP_ADDI, rs, rt, imm);
            MnAddiu: word = enc_i(OP_ADDIU, rs, rt, imm);
            MnAndi:  word = enc_i(OP_ANDI, rs, rt, imm);
            MnSlti:  word = enc_i(OP_SLTI, rs, rt, imm);
            MnSltiu: word = enc_i(OP_SLTIU, rs, rt, imm);
            MnBeq:   word = enc_i(OP_BEQ, rs, rt, imm);
            MnJ:     word = enc_j(OP_J, target);
            MnJal:   word = enc_j(OP_JAL, target);
            default: illegal = 1'b1;
        endcase
        // Wider mnemonic buses: anything beyond the 5-bit table is illegal.
        if (|mnem_ext[31:5]) begin
            word    = '0;
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams symbolic instructions into instruction memory as encoded MIPS words,
// one write per legal instruction at consecutive word addresses.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MNEM_W = 5
) (
    input logic          clk,
    input logic          reset,
    instr_encoder_if.slave bus
);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       count_q, count_d;
    logic              err_q, err_d;
    logic              in_ready;
    logic              accept;
    logic [31:0]       enc_word;
    logic              enc_illegal;

    instr_encode_comb #(
        .MNEM_W(MNEM_W)
    ) u_encode (
        .mnem    (bus.in_mnem),
        .rs      (bus.in_rs),
        .rt      (bus.in_rt),
        .rd      (bus.in_rd),
        .shamt   (bus.in_shamt),
        .imm     (bus.in_imm),
        .target  (bus.in_target),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // start takes priority over a pending instruction in idle.
    assign in_ready = ((state_q == StIdle) && !bus.start) ||
                      ((state_q == StWrite) && bus.mem_ready && !last_q);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    addr_d  = {bus.start_addr[ADDR_W-1:2], 2'b00};
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            StWrite: begin
                if (bus.mem_ready) begin
                    addr_d = addr_q + ADDR_W'(4);
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    we_d    = 1'b0;
                    state_d = last_q ? StDone : StIdle;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A new instruction overrides the idle/drain decision above.
        if (accept) begin
            if (!enc_illegal) begin
                wdata_d = enc_word;
                we_d    = 1'b1;
                last_d  = bus.in_last;
                state_d = StWrite;
            end else begin
                err_d   = 1'b1;
                we_d    = 1'b0;
                state_d = bus.in_last ? StDone : StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.instr_count = count_q;
    assign bus.err_illegal = err_q;
    assign bus.done        = (state_q == StDone);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench: directed program loads plus random streams against a
// transaction-level model of the encoder (expected-write queue, address and counters).
module tb_instr_encoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset8 = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_encoder_if #(.ADDR_W(32), .MNEM_W(5)) bus ();
    instr_encoder_if #(.ADDR_W(8), .MNEM_W(5)) bus8 ();

    instr_encoder #(.ADDR_W(32), .MNEM_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
    instr_encoder #(.ADDR_W(8), .MNEM_W(5)) dut8 (.clk(clk), .reset(reset8), .bus(bus8));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoding: {illegal, word}, built from the mnemonic table with shifts.
    function automatic logic [32:0] model_enc(input int unsigned m, input int unsigned rs,
                                              input int unsigned rt, input int unsigned rd,
                                              input int unsigned sh, input int unsigned imm,
                                              input int unsigned tgt);
        int unsigned k, c, w;
        k = 9; c = 0; w = 0;
        case (m)
            0: begin k = 0; c = 'h20; end  1: begin k = 0; c = 'h21; end
            2: begin k = 0; c = 'h22; end  3: begin k = 0; c = 'h23; end
            4: begin k = 0; c = 'h24; end  5: begin k = 0; c = 'h25; end
            6: begin k = 0; c = 'h26; end  7: begin k = 0; c = 'h27; end
            8: begin k = 0; c = 'h2a; end  9: begin k = 0; c = 'h2b; end
            10: begin k = 1; c = 'h00; end 11: begin k = 1; c = 'h02; end
            12: begin k = 1; c = 'h03; end 13: begin k = 2; c = 'h08; end
            14: begin k = 3; c = 'h09; end 15: begin k = 4; c = 'h23; end
            16: begin k = 4; c = 'h2b; end 17: begin k = 5; c = 'h0f; end
            18: begin k = 4; c = 'h08; end 19: begin k = 4; c = 'h09; end
            20: begin k = 4; c = 'h0c; end 21: begin k = 4; c = 'h0a; end
            22: begin k = 4; c = 'h0b; end 23: begin k = 4; c = 'h04; end
            24: begin k = 6; c = 'h02; end 25: begin k = 6; c = 'h03; end
            default: k = 9;
        endcase
        case (k)
            0: w = (rs << 21) | (rt << 16) | (rd << 11) | c;
            1: w = (rt << 16) | (rd << 11) | (sh << 6) | c;
            2: w = (rs << 21) | c;
            3: w = (rs << 21) | (rd << 11) | c;
            4: w = (c << 26) | (rs << 21) | (rt << 16) | imm;
            5: w = (c << 26) | (rt << 16) | imm;
            6: w = (c << 26) | tgt;
            default: w = 0;
        endcase
        return {k == 9, w};
    endfunction

    typedef struct {
        logic [31:0] w;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wr_data[$];
    logic [31:0] wr_addr[$];
    int          wr_cyc[$];
    logic [31:0] m_addr = '0;
    logic [15:0] m_count = '0;
    bit          m_err = 0;
    bit          pend_done = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    // Compare process: checks every cycle, then advances the model.
    always @(negedge clk) begin
        logic [32:0] enc;
        if (reset) begin
            exp_q.delete();
            m_addr = '0; m_count = '0; m_err = 0; pend_done = 0; prev_stall = 0;
        end else begin
            check("done", 64'(bus.done), 64'(pend_done));
            check("instr_count", 64'(bus.instr_count), 64'(m_count));
            check("err_illegal", 64'(bus.err_illegal), 64'(m_err));
            check("mem_we", 64'(bus.mem_we), 64'(exp_q.size() != 0));
            if (prev_stall) begin
                check("hold_addr", 64'(bus.mem_addr), 64'(prev_addr));
                check("hold_data", 64'(bus.mem_wdata), 64'(prev_data));
            end
            if ((bus.mem_we && !bus.mem_ready) || pend_done || (bus.start && bus.in_valid))
                check("in_ready_low", 64'(bus.in_ready), 64'd0);
            pend_done = 0;
            if (bus.mem_we && bus.mem_ready && exp_q.size() != 0) begin
                check("wr_data", 64'(bus.mem_wdata), 64'(exp_q[0].w));
                check("wr_addr", 64'(bus.mem_addr), 64'(m_addr));
                wr_data.push_back(bus.mem_wdata);
                wr_addr.push_back(bus.mem_addr);
                wr_cyc.push_back(cyc);
                pend_done = exp_q[0].last;
                void'(exp_q.pop_front());
                m_addr = m_addr + 32'd4;
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            end
            if (bus.start) begin
                m_addr = bus.start_addr & ~32'd3;
                m_count = '0;
                m_err = 0;
            end
            if (bus.in_valid && bus.in_ready) begin
                enc = model_enc(32'(bus.in_mnem), 32'(bus.in_rs), 32'(bus.in_rt),
                                32'(bus.in_rd), 32'(bus.in_shamt), 32'(bus.in_imm),
                                32'(bus.in_target));
                if (enc[32]) begin
                    m_err = 1;
                    if (bus.in_last) pend_done = 1;
                end else begin
                    exp_q.push_back('{enc[31:0], bus.in_last});
                end
            end
            prev_stall = bus.mem_we && !bus.mem_ready;
            prev_addr = bus.mem_addr;
            prev_data = bus.mem_wdata;
        end
    end

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0: bus.mem_ready = 1'b1;
            1: bus.mem_ready = 1'($urandom_range(0, 1));
            default: bus.mem_ready = 1'b0;
        endcase
    end

    task automatic drive(input int unsigned m, input int unsigned rs, input int unsigned rt,
                         input int unsigned rd, input int unsigned sh, input int unsigned imm,
                         input int unsigned tgt, input bit last);
        bus.in_mnem = 5'(m); bus.in_rs = 5'(rs); bus.in_rt = 5'(rt); bus.in_rd = 5'(rd);
        bus.in_shamt = 5'(sh); bus.in_imm = 16'(imm); bus.in_target = 26'(tgt);
        bus.in_last = last; bus.in_valid = 1'b1;
    endtask

    // Entered and left at posedge+1; returns after the accepting edge.
    task automatic send(input int unsigned m, input int unsigned rs, input int unsigned rt,
                        input int unsigned rd, input int unsigned sh, input int unsigned imm,
                        input int unsigned tgt, input bit last);
        int n = 0;
        drive(m, rs, rt, rd, sh, imm, tgt, last);
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        if (!bus.in_ready) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic start_at(input logic [31:0] a);
        bus.start = 1'b1; bus.start_addr = a;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int n = 0;
        bit seen = 0;
        while (!seen && n < bound) begin
            @(negedge clk);
            n++;
            if (bus.done) seen = 1;
        end
        check(name, 64'(seen), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start = 0; bus.start_addr = '0; bus.in_valid = 0; bus.mem_ready = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 0;
        bus8.start = 0; bus8.start_addr = '0; bus8.in_valid = 0; bus8.mem_ready = 1;
        bus8.in_mnem = '0; bus8.in_rs = '0; bus8.in_rt = '0; bus8.in_rd = '0;
        bus8.in_shamt = '0; bus8.in_imm = '0; bus8.in_target = '0; bus8.in_last = 0;

        // Pin the reference model to hand-computed words.
        check("pin_addu", 64'(model_enc(1, 1, 2, 3, 0, 0, 0)), 64'h0_0022_1821);
        check("pin_lw", 64'(model_enc(15, 29, 8, 0, 0, 4, 0)), 64'h0_8FA8_0004);
        check("pin_beq", 64'(model_enc(23, 8, 0, 0, 0, 'hFFFF, 0)), 64'h0_1100_FFFF);
        check("pin_jal", 64'(model_enc(25, 0, 0, 0, 0, 0, 'h0100000)), 64'h0_0C10_0000);
        check("pin_sll", 64'(model_enc(10, 7, 3, 2, 4, 0, 0)), 64'h0_0003_1100);
        check("pin_lui", 64'(model_enc(17, 5, 1, 0, 0, 'h1234, 0)), 64'h0_3C01_1234);
        check("pin_jr", 64'(model_enc(13, 31, 0, 0, 0, 0, 0)), 64'h0_03E0_0008);
        check("pin_illegal", 64'(model_enc(27, 1, 1, 1, 1, 1, 1) >> 32), 64'd1);

        repeat (2) @(posedge clk);
        #1 reset = 0; reset8 = 0;
        check("rst_we", 64'(bus.mem_we), 64'd0);
        check("rst_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_count", 64'(bus.instr_count), 64'd0);
        check("rst_err", 64'(bus.err_illegal), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_ready", 64'(bus.in_ready), 64'd1);

        // Single addu with in_last.
        start_at(32'h0040_0000);
        send(1, 1, 2, 3, 0, 0, 0, 1);
        wait_done(20, "addu_done");
        check("addu_word", 64'(wr_data[$]), 64'h0022_1821);
        check("addu_addr", 64'(wr_addr[$]), 64'h0040_0000);
        check("addu_count", 64'(bus.instr_count), 64'd1);

        // Back-to-back stream.
        start_at(32'h0000_0100);
        send(15, 29, 8, 0, 0, 'h0004, 0, 0);
        send(23, 8, 0, 0, 0, 'hFFFF, 0, 0);
        send(25, 0, 0, 0, 0, 0, 'h0100000, 1);
        wait_done(20, "stream_done");
        n = wr_data.size();
        check("stream_w0", 64'(wr_data[n-3]), 64'h8FA8_0004);
        check("stream_w1", 64'(wr_data[n-2]), 64'h1100_FFFF);
        check("stream_w2", 64'(wr_data[n-1]), 64'h0C10_0000);
        check("stream_a2", 64'(wr_addr[n-1]), 64'h0000_0108);
        check("stream_nobubble", 64'(wr_cyc[n-1] - wr_cyc[n-3]), 64'd2);
        check("stream_count", 64'(bus.instr_count), 64'd3);

        // rs forced to zero for shifts and lui.
        start_at(32'h0000_0200);
        send(10, 7, 3, 2, 4, 0, 0, 0);
        send(17, 5, 1, 0, 0, 'h1234, 0, 1);
        wait_done(20, "force_done");
        n = wr_data.size();
        check("sll_word", 64'(wr_data[n-2]), 64'h0003_1100);
        check("lui_word", 64'(wr_data[n-1]), 64'h3C01_1234);

        // Memory stall for five cycles.
        rdy_mode = 2;
        start_at(32'h0000_0300);
        send(0, 4, 5, 6, 0, 0, 0, 1);
        repeat (5) begin
            @(negedge clk);
            check("stall_we", 64'(bus.mem_we), 64'd1);
            check("stall_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1 rdy_mode = 0;
        @(negedge clk);
        check("stall_pending_count", 64'(bus.instr_count), 64'd0);
        @(negedge clk);
        check("stall_we_drop", 64'(bus.mem_we), 64'd0);
        check("stall_done", 64'(bus.done), 64'd1);
        check("stall_count", 64'(bus.instr_count), 64'd1);
        @(posedge clk);
        #1;

        // Illegal mnemonic then jr; sticky error cleared by the next start.
        start_at(32'h0000_0400);
        send(27, 1, 2, 3, 0, 0, 0, 0);
        send(13, 31, 0, 0, 0, 0, 0, 1);
        wait_done(20, "illegal_done");
        check("illegal_err", 64'(bus.err_illegal), 64'd1);
        check("illegal_count", 64'(bus.instr_count), 64'd1);
        check("jr_word", 64'(wr_data[$]), 64'h03E0_0008);
        drive(1, 1, 2, 3, 0, 0, 0, 1);
        bus.start = 1'b1; bus.start_addr = 32'h0000_0503;
        @(negedge clk);
        check("start_wins", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("err_cleared", 64'(bus.err_illegal), 64'd0);
        send(1, 1, 2, 3, 0, 0, 0, 1);
        wait_done(20, "restart_done");
        check("restart_addr", 64'(wr_addr[$]), 64'h0000_0500);

        // Random programs with random memory back-pressure.
        rdy_mode = 1;
        for (int p = 0; p < 4; p++) begin
            start_at($urandom());
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 'hFFFF),
                     $urandom_range(0, 'h3FF_FFFF), i == 39);
            end
            wait_done(500, "rand_done");
        end
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // 8-bit address wrap and asynchronous reset mid-write.
        bus8.start = 1; bus8.start_addr = 8'hFD;
        @(posedge clk);
        #1 bus8.start = 0;
        bus8.in_valid = 1; bus8.in_mnem = 5'd0; bus8.in_rs = 5'd1; bus8.in_rt = 5'd2;
        bus8.in_rd = 5'd3; bus8.in_last = 0;
        @(posedge clk);
        #1;
        check("a8_first_addr", 64'(bus8.mem_addr), 64'hFC);
        check("a8_first_we", 64'(bus8.mem_we), 64'd1);
        check("a8_first_data", 64'(bus8.mem_wdata), 64'h0022_1820);
        bus8.in_mnem = 5'd2; bus8.in_rs = 5'd4; bus8.in_rt = 5'd5; bus8.in_rd = 5'd6;
        @(posedge clk);
        #1 bus8.in_valid = 0; bus8.mem_ready = 0;
        check("a8_wrap_addr", 64'(bus8.mem_addr), 64'h00);
        check("a8_second_we", 64'(bus8.mem_we), 64'd1);
        check("a8_second_data", 64'(bus8.mem_wdata), 64'(model_enc(2, 4, 5, 6, 0, 0, 0)));
        check("a8_count", 64'(bus8.instr_count), 64'd1);
        #2 reset8 = 1;
        #1;
        check("a8_rst_we", 64'(bus8.mem_we), 64'd0);
        check("a8_rst_addr", 64'(bus8.mem_addr), 64'd0);
        check("a8_rst_data", 64'(bus8.mem_wdata), 64'd0);
        check("a8_rst_count", 64'(bus8.instr_count), 64'd0);
        @(posedge clk);
        #1 reset8 = 0;

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the single-cycle CPU's control/instruction decode: turns a stream of symbolic instructions (mnemonic index plus fields) into 32-bit MIPS words.
- Writes each word sequentially into instruction memory through a valid/ready stream on the input and a write strobe with stall on the memory side.
- Used by the test-program loader to fill instruction ROM/RAM before the CPU is released from reset.

Parameters:
ADDR_W, 32, byte-address width of mem_addr; address arithmetic wraps modulo 2^ADDR_W
MNEM_W, 5, width of mnemonic index

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; honoured in S_IDLE only: load address, clear count/error
start_addr  in  ADDR_W  first write address; low 2 bits ignored (forced 0)
in_valid  in  1  symbolic instruction present
in_ready  out  1  encoder accepts this cycle
in_mnem  in  MNEM_W  mnemonic index (see Behaviour)
in_rs, in_rt, in_rd  in  5 each  register fields
in_shamt  in  5  shift amount
in_imm  in  16  immediate / branch offset
in_target  in  26  jump target field
in_last  in  1  marks final instruction of the program
mem_we  out  1  write request, held until mem_ready
mem_ready  in  1  memory accepts write this cycle
mem_addr  out  ADDR_W  word-aligned write address
mem_wdata  out  32  encoded instruction
instr_count  out  16  words written since start; saturates at 16'hFFFF
err_illegal  out  1  sticky: an illegal mnemonic was received
done  out  1  one-cycle pulse after the last instruction completes

Behaviour:
- Reset values:
  - mem_we=0, mem_addr=0, mem_wdata=0, instr_count=0, err_illegal=0, done=0.
  - State S_IDLE; internal last flag=0.
- Mnemonic map (index -> encoding):
  - R-type {6'h00,rs,rt,rd,shamt,funct}: 0 add/20, 1 addu/21, 2 sub/22, 3 subu/23, 4 and/24, 5 or/25, 6 xor/26, 7 nor/27, 8 slt/2a, 9 sltu/2b, shamt forced 0 for all of these.
  - Shifts, rs forced 0: 10 sll/00, 11 srl/02, 12 sra/03.
  - 13 jr: {0,rs,0,0,0,08}. 14 jalr: {0,rs,0,rd,0,09}.
  - I-type {op,rs,rt,imm}: 15 lw/23, 16 sw/2b, 17 lui/0f (rs forced 0), 18 addi/08, 19 addiu/09, 20 andi/0c, 21 slti/0a, 22 sltiu/0b, 23 beq/04.
  - J-type {op,target}: 24 j/02, 25 jal/03.
  - Indices 26-31 are illegal.
- States: S_IDLE, S_WRITE, S_DONE.
- in_ready = (state==S_IDLE) | (state==S_WRITE & mem_ready & ~last_flag). Never 1 in S_DONE.
- Accept = in_valid & in_ready, legal mnemonic:
  - Register mem_wdata = encoded word, mem_we=1, last_flag=in_last, go to S_WRITE.
  - Latency: accept edge -> mem_we visible the next cycle.
- Accept, illegal mnemonic:
  - No write. err_illegal<=1 (sticky). Address and count unchanged.
  - If in_last, go to S_DONE; otherwise stay in or return to S_IDLE, dropping mem_we if it was completing.
- S_WRITE:
  - mem_we, mem_addr and mem_wdata stay stable until mem_ready=1.
  - On mem_ready: mem_addr+=4 (wraps), instr_count+=1 (saturating).
  - If last_flag: mem_we<=0, go to S_DONE.
  - Else if a simultaneous accept occurs: load the new word back-to-back, stay in S_WRITE.
  - Else: mem_we<=0, go to S_IDLE.
- S_DONE: done=1 for exactly one cycle, then S_IDLE. mem_addr and instr_count are retained.
- start:
  - In S_IDLE: mem_addr<={start_addr[ADDR_W-1:2],2'b00}, instr_count=0, err_illegal=0.
  - Ignored in any other state.
  - start and in_valid in the same S_IDLE cycle: start wins, in_ready=0 that cycle.
- Without start after reset, writing begins at address 0.
- Reset mid-write: outputs return to reset values immediately (asynchronous). Any pending word is lost.

Decomposition:
- Shared package holds:
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_LUI, OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_BEQ, OP_J, OP_JAL).
  - Funct constants.
  - Mnemonic index enum.
  - FSM state encoding.
- The decoder should use the same opcode/funct constants.
- One sub-module, instr_encode_comb: purely combinational mnem+fields -> {word, illegal}. The top handles the FSM, counters and handshake.

Test Plan:
- reset, start with start_addr=0x0040_0000, send addu rs=1 rt=2 rd=3 with in_last, mem_ready=1 -> one write 0x00221821 @0x00400000; done one cycle later; instr_count=1.
- Stream lw rt=8 rs=29 imm=0x0004, beq rs=8 rt=0 imm=0xFFFF, jal target=0x0100000 back-to-back with mem_ready=1 -> writes 0x8FA80004, 0x1100FFFF, 0x0C100000 at consecutive addresses, no bubbles; instr_count=3.
- sll rd=2 rt=3 shamt=4 with in_rs=7, and lui rt=1 imm=0x1234 with in_rs=5 -> 0x00031100 and 0x3C011234 (rs fields forced 0).
- mem_ready held 0 for 5 cycles during a write -> mem_we, mem_addr and mem_wdata stable and in_ready=0 throughout; write completes on the cycle mem_ready rises.
- Mnemonic 27 followed by legal jr rs=31 with in_last -> err_illegal=1 (sticky), single write 0x03E00008, instr_count=1; next start clears err_illegal.
- ADDR_W=8, start_addr=0xFC, two instructions -> writes at 0xFC then 0x00 (wrap). Assert reset during the second write -> mem_we=0 and mem_addr=0 asynchronously.
